// File: rtl/multi_debounce.sv
// -----------------------------------------------------------------------------
// multi_debounce
//   Multi-channel mechanical button conditioner. Every channel is synchronised,
//   debounced with its own stability counter, and decoded into single-cycle
//   press, release, long-press and auto-repeat pulses. Channels share only the
//   clock, the reset and the parameters.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst            asynchronous, active-low reset
//   noisy_btn      raw asynchronous button inputs, one bit per channel
//   clean_btn      registered debounced level, 1 = pressed
//   press_pulse    1-cycle pulse on clean 0->1
//   release_pulse  1-cycle pulse on clean 1->0
//   long_pulse     1-cycle pulse LONG_PRESS cycles after press_pulse
//   repeat_pulse   1-cycle pulse every REPEAT_PERIOD cycles after long_pulse
// -----------------------------------------------------------------------------
module multi_debounce #(
   parameter int unsigned       NUM_CH          = 4,
   parameter int unsigned       DEBOUNCE_DELAY  = 20,
   parameter int unsigned       SYNC_STAGES     = 2,
   parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = {NUM_CH{1'b0}},
   parameter int unsigned       LONG_PRESS      = 100,
   parameter int unsigned       REPEAT_PERIOD   = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] noisy_btn,
   output logic [NUM_CH-1:0] clean_btn,
   output logic [NUM_CH-1:0] press_pulse,
   output logic [NUM_CH-1:0] release_pulse,
   output logic [NUM_CH-1:0] long_pulse,
   output logic [NUM_CH-1:0] repeat_pulse
);

   localparam int unsigned     DB_W    = $clog2(DEBOUNCE_DELAY + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_DELAY - 1);

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic                   in_lvl;
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s_lvl;
      logic [DB_W-1:0]        db_cnt;
      logic                   db_done;
      logic                   rise;
      logic                   fall;
      logic                   clean_q;
      logic                   press_q;
      logic                   rel_q;

      // Polarity is normalised before the synchroniser, so the released level
      // is always 0 inside the channel and the reset value of the flops.
      assign in_lvl = noisy_btn[ch] ^ ACTIVE_LOW_MASK[ch];
      assign s_lvl  = sync_q[SYNC_STAGES-1];

      // ---- stage: synchroniser ----
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_lvl};
         end
      end

      assign db_done = (s_lvl != clean_q) && (db_cnt == DB_LAST);
      assign rise    = db_done && s_lvl;
      assign fall    = db_done && !s_lvl;

      // ---- stage: debounce and edge decode ----
      // Any cycle where the synchronised level matches the clean level restarts
      // the count, so a bounce shorter than DEBOUNCE_DELAY never gets through.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            clean_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            db_cnt  <= '0;
         end else begin
            press_q <= rise;
            rel_q   <= fall;
            if (db_done) begin
               clean_q <= s_lvl;
               db_cnt  <= '0;
            end else if (s_lvl != clean_q) begin
               db_cnt <= db_cnt + 1'b1;
            end else begin
               db_cnt <= '0;
            end
         end
      end

      assign clean_btn[ch]     = clean_q;
      assign press_pulse[ch]   = press_q;
      assign release_pulse[ch] = rel_q;

      if (LONG_PRESS > 0) begin : g_long
         localparam int unsigned       HOLD_MAX  = (LONG_PRESS > REPEAT_PERIOD) ?
                                                   LONG_PRESS : REPEAT_PERIOD;
         localparam int unsigned       HOLD_W    = $clog2(HOLD_MAX + 1);
         localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS - 1);

         logic [HOLD_W-1:0] hold_cnt;
         logic              long_done;
         logic              long_q;
         logic              hold_on;

         // A release on this edge counts as not held, which is what suppresses
         // a long/repeat pulse that would otherwise coincide with it.
         assign hold_on = clean_q && !fall;

         // ---- stage: hold timing ----
         // hold_cnt saturates at LONG_LAST; long_done keeps long_pulse to one
         // shot per press while the counter sits there.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hold_cnt  <= '0;
               long_done <= 1'b0;
               long_q    <= 1'b0;
            end else begin
               long_q <= 1'b0;
               if (!hold_on) begin
                  hold_cnt  <= '0;
                  long_done <= 1'b0;
               end else if (hold_cnt == LONG_LAST) begin
                  if (!long_done) begin
                     long_q    <= 1'b1;
                     long_done <= 1'b1;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
         end

         assign long_pulse[ch] = long_q;

         if (REPEAT_PERIOD > 0) begin : g_rep
            localparam int unsigned     PH_W     = $clog2(REPEAT_PERIOD + 1);
            localparam logic [PH_W-1:0] REP_LAST = PH_W'(REPEAT_PERIOD - 1);

            logic [PH_W-1:0] ph_cnt;
            logic            rep_q;

            // ---- stage: repeat phase ----
            // Phase starts at 0 on the long_pulse edge, so the first repeat
            // lands REPEAT_PERIOD cycles after long_pulse and then wraps.
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  ph_cnt <= '0;
                  rep_q  <= 1'b0;
               end else begin
                  rep_q <= 1'b0;
                  if (!hold_on || !long_done) begin
                     ph_cnt <= '0;
                  end else if (ph_cnt == REP_LAST) begin
                     rep_q  <= 1'b1;
                     ph_cnt <= '0;
                  end else begin
                     ph_cnt <= ph_cnt + 1'b1;
                  end
               end
            end

            assign repeat_pulse[ch] = rep_q;
         end else begin : g_no_rep
            assign repeat_pulse[ch] = 1'b0;
         end
      end else begin : g_no_long
         assign long_pulse[ch]   = 1'b0;
         assign repeat_pulse[ch] = 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_debounce.sv
// -----------------------------------------------------------------------------
// tb_multi_debounce
//   Directed bench for multi_debounce. One instance uses default parameters,
//   a second uses ACTIVE_LOW_MASK = 4'b1000. Edges are numbered from the last
//   reset release; expected output vectors are written per edge from the
//   hand-derived event times (press/release 22 edges after a stable level,
//   long +100 and repeat +150/+200/... after press_pulse).
// -----------------------------------------------------------------------------
module tb_multi_debounce;

   logic       clk;
   logic       rst;
   logic [3:0] noisy;
   logic [3:0] noisy_al;

   logic [3:0] clean_m, press_m, rel_m, long_m, rep_m;
   logic [3:0] clean_a, press_a, rel_a, long_a, rep_a;

   logic [19:0] obs_m;
   logic [19:0] obs_a;

   assign obs_m = {clean_m, press_m, rel_m, long_m, rep_m};
   assign obs_a = {clean_a, press_a, rel_a, long_a, rep_a};

   int checks;
   int errors;
   int edge_n;

   logic [3:0] ec, ep, er, el, erp;

   multi_debounce dut (
      .clk           (clk),
      .rst           (rst),
      .noisy_btn     (noisy),
      .clean_btn     (clean_m),
      .press_pulse   (press_m),
      .release_pulse (rel_m),
      .long_pulse    (long_m),
      .repeat_pulse  (rep_m)
   );

   multi_debounce #(.ACTIVE_LOW_MASK(4'b1000)) dut_al (
      .clk           (clk),
      .rst           (rst),
      .noisy_btn     (noisy_al),
      .clean_btn     (clean_a),
      .press_pulse   (press_a),
      .release_pulse (rel_a),
      .long_pulse    (long_a),
      .repeat_pulse  (rep_a)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%05h expected=%05h (clean,press,release,long,repeat)",
                tag, edge_n, obs, exp_v);
      end
   endtask

   task automatic clr_exp();
      ec = '0; ep = '0; er = '0; el = '0; erp = '0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      edge_n   = 0;
      rst      = 1'b1;
      noisy    = 4'b0101;
      noisy_al = 4'b1000;
      clr_exp();

      // ---- reset held two cycles, pressed levels present ----
      #2 rst = 1'b0;
      tick();
      check("rst_hold", obs_m, '0);
      check("rst_hold_al", obs_a, '0);
      tick();
      check("rst_hold", obs_m, '0);
      check("rst_hold_al", obs_a, '0);
      rst    = 1'b1;
      edge_n = 0;

      // ---- release from reset: press at edge 22 on ch0/ch2 ----
      for (int n = 1; n <= 23; n++) begin
         tick();
         clr_exp();
         ec = (edge_n >= 22) ? 4'b0101 : 4'b0000;
         ep = (edge_n == 22) ? 4'b0101 : 4'b0000;
         check("reset_release", obs_m, {ec, ep, er, el, erp});
         check("reset_release_al", obs_a, '0);
      end

      // ---- ch0 release with bounce 0,1,0; ch2 clean release ----
      noisy = 4'b0000;
      while (edge_n < 50) begin
         tick();
         clr_exp();
         ec    = (edge_n < 45) ? 4'b0101 : ((edge_n < 47) ? 4'b0001 : 4'b0000);
         er[2] = (edge_n == 45);
         er[0] = (edge_n == 47);
         check("release_bounce", obs_m, {ec, ep, er, el, erp});
         if (edge_n == 24) noisy[0] = 1'b1;
         if (edge_n == 25) noisy[0] = 1'b0;
      end

      // ---- ch0 press bounce: toggle 8 cycles then hold ----
      for (int k = 0; k < 8; k++) begin
         noisy[0] = (k % 2 == 0);
         tick();
         check("bounce_toggle", obs_m, '0);
      end
      noisy[0] = 1'b1;
      while (edge_n < 81) begin
         tick();
         clr_exp();
         ec[0] = (edge_n >= 80);
         ep[0] = (edge_n == 80);
         check("bounce_press", obs_m, {ec, ep, er, el, erp});
      end

      // ---- ch0 release with ch2 press on the same edge, then ch2 long/repeat,
      //      ch2 release on a repeat threshold, ch3 press, ch1 mid-count ----
      noisy = 4'b0100;
      while (edge_n < 530) begin
         tick();
         clr_exp();
         ec[0]  = (edge_n < 103);
         ec[2]  = (edge_n >= 103) && (edge_n < 453);
         ec[3]  = (edge_n >= 482);
         ep[2]  = (edge_n == 103);
         ep[3]  = (edge_n == 482);
         er[0]  = (edge_n == 103);
         er[2]  = (edge_n == 453);
         el[2]  = (edge_n == 203);
         erp[2] = (edge_n == 253) || (edge_n == 303) || (edge_n == 353) || (edge_n == 403);
         check("long_repeat", obs_m, {ec, ep, er, el, erp});
         if (edge_n == 431) noisy[2] = 1'b0;
         if (edge_n == 460) noisy[3] = 1'b1;
         if (edge_n == 520) noisy[1] = 1'b1;
      end

      // ---- asynchronous reset mid-cycle while ch1 counts and ch3 is pressed ----
      #3 rst = 1'b0;
      #1;
      check("async_rst", obs_m, '0);
      check("async_rst_al", obs_a, '0);
      tick();
      check("rst_hold2", obs_m, '0);
      tick();
      check("rst_hold2", obs_m, '0);
      rst    = 1'b1;
      edge_n = 0;

      // ---- recovery: ch1/ch3 re-press at 22; active-low ch3 press at 27 ----
      while (edge_n < 40) begin
         tick();
         clr_exp();
         ec = (edge_n >= 22) ? 4'b1010 : 4'b0000;
         ep = (edge_n == 22) ? 4'b1010 : 4'b0000;
         check("post_reset", obs_m, {ec, ep, er, el, erp});
         clr_exp();
         ec[3] = (edge_n >= 27);
         ep[3] = (edge_n == 27);
         check("active_low", obs_a, {ec, ep, er, el, erp});
         if (edge_n == 5) noisy_al = 4'b0000;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
